iob_ila_dump_ctrl: RTL and testbench

Hardware readout sequencer for the ILA sample buffer, so captured samples are drained without CPU involvement.
- Acts as an IOb-Native master on the ILA register bus.
- Reads N_SAMPLES, then for each sample index writes INDEX and SIGNAL_SELECT and reads SAMPLE_DATA.
- Streams every word out on a valid/ready port to a debug UART/Ethernet bridge.
- Sits between the ILA register split and the bus arbiter, next to the CPU master.

---
 rtl/iob_ila_dump_pkg.sv | 24 ++
 rtl/iob_ila_dump_master.sv | 56 +++++
 rtl/iob_ila_dump_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_iob_ila_dump_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ila_dump_pkg.sv
// Shared definitions for the ILA dump sequencer: FSM encoding and ILA register map.
// Latency: n/a (constants only).
// Backpressure: n/a.
package iob_ila_dump_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] RD_NS  = 4'd1;
    localparam logic [STATE_W-1:0] W_NS   = 4'd2;
    localparam logic [STATE_W-1:0] WR_IDX = 4'd3;
    localparam logic [STATE_W-1:0] WR_SEL = 4'd4;
    localparam logic [STATE_W-1:0] RD_DAT = 4'd5;
    localparam logic [STATE_W-1:0] W_DAT  = 4'd6;
    localparam logic [STATE_W-1:0] PUSH   = 4'd7;
    localparam logic [STATE_W-1:0] FIN    = 4'd8;

    // ILA register map (byte addresses)
    localparam logic [7:0] ILA_INDEX_ADDR  = 8'h10;
    localparam logic [7:0] ILA_SEL_ADDR    = 8'h14;
    localparam logic [7:0] ILA_SAMPLE_ADDR = 8'h18;
    localparam logic [7:0] ILA_NSAMP_ADDR  = 8'h1C;

endpackage

// File: rtl/iob_ila_dump_master.sv
// IOb-Native single-transaction master: one read or write per req, reports accept and completion.
// Latency: request visible the cycle req_i is high; writes complete on accept, reads on rvalid.
// Backpressure: request held until m_ready_i; no new request while a read is outstanding.
module iob_ila_dump_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                acc_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_ready_i,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i
);

    logic pend_q, pend_d;

    // Remember the single outstanding read between accept and rvalid
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pend_q <= 1'b0;
        end else if (cke_i) begin
            pend_q <= pend_d;
        end
    end

    // Drive the request and decode accept / completion; avalid is masked while the
    // clock is disabled so the bus never sees a transfer this side cannot record
    always_comb begin
        m_avalid_o = req_i && !pend_q && cke_i;
        m_addr_o   = addr_i;
        m_wdata_o  = wdata_i;
        m_wstrb_o  = (req_i && we_i) ? '1 : '0;
        acc_o      = m_avalid_o && m_ready_i;
        done_o     = (acc_o && we_i) || (pend_q && m_rvalid_i && cke_i);
        rdata_o    = m_rdata_i;
        pend_d     = pend_q;
        if (acc_o && !we_i) begin
            pend_d = 1'b1;
        end else if (pend_q && m_rvalid_i) begin
            pend_d = 1'b0;
        end
    end

endmodule

// File: rtl/iob_ila_dump_ctrl.sv
// ILA readout sequencer: reads N_SAMPLES, then per sample/word writes INDEX, SIGNAL_SELECT, reads SAMPLE_DATA, streams it.
// Latency: first bus request 1 cycle after start_i; 5 cycles per word on a zero-wait bus (4 when INDEX is unchanged).
// Backpressure: bus stalls hold the request stable; stream stalls hold s_* stable and issue no bus traffic.
module iob_ila_dump_ctrl
    import iob_ila_dump_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                BUFFER_W    = 10,
    parameter int                SEL_W       = 8,
    parameter logic [ADDR_W-1:0] INDEX_ADDR  = ILA_INDEX_ADDR,
    parameter logic [ADDR_W-1:0] SEL_ADDR    = ILA_SEL_ADDR,
    parameter logic [ADDR_W-1:0] SAMPLE_ADDR = ILA_SAMPLE_ADDR,
    parameter logic [ADDR_W-1:0] NSAMP_ADDR  = ILA_NSAMP_ADDR
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [SEL_W-1:0]    words_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_ready_i,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    output logic                s_valid_o,
    output logic [DATA_W-1:0]   s_data_o,
    output logic                s_last_o,
    input  logic                s_ready_i
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [SEL_W-1:0]    wcnt_q, wcnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [BUFFER_W-1:0] n_q, n_d;
    logic [BUFFER_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                abort_q, abort_d;

    logic                busy, abt, last_sel, last_idx, s_hs;
    logic                mst_req, mst_we, mst_acc, mst_done;
    logic [ADDR_W-1:0]   mst_addr;
    logic [DATA_W-1:0]   mst_wdata, mst_rdata;

    assign busy     = (state_q != IDLE) && (state_q != FIN);
    assign abt      = abort_q || (busy && abort_i);
    assign last_sel = (sel_q == wcnt_q - SEL_W'(1));
    assign last_idx = (idx_q == n_q - BUFFER_W'(1));
    assign s_hs     = s_valid_o && s_ready_i;

    iob_ila_dump_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_master (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .req_i      (mst_req),
        .we_i       (mst_we),
        .addr_i     (mst_addr),
        .wdata_i    (mst_wdata),
        .acc_o      (mst_acc),
        .done_o     (mst_done),
        .rdata_o    (mst_rdata),
        .m_avalid_o (m_avalid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
    );

    // State and datapath registers; everything freezes while cke_i is low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            sel_q   <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            sel_q   <= sel_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            abort_q <= abort_d;
        end
    end

    // Next-state and counter updates; an abort lets the in-flight bus transfer finish first
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        sel_d   = sel_q;
        n_d     = n_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    wcnt_d  = (words_i == '0) ? SEL_W'(1) : words_i;
                    idx_d   = '0;
                    sel_d   = '0;
                    state_d = RD_NS;
                end
            end
            RD_NS:  if (mst_acc) state_d = W_NS;
            W_NS: begin
                if (mst_done) begin
                    if (abt) begin
                        state_d = IDLE;
                    end else begin
                        n_d     = mst_rdata[BUFFER_W-1:0];
                        state_d = (mst_rdata[BUFFER_W-1:0] == '0) ? FIN : WR_IDX;
                    end
                end
            end
            WR_IDX: if (mst_acc) state_d = abt ? IDLE : WR_SEL;
            WR_SEL: if (mst_acc) state_d = abt ? IDLE : RD_DAT;
            RD_DAT: if (mst_acc) state_d = W_DAT;
            W_DAT: begin
                if (mst_done) begin
                    if (abt) begin
                        state_d = IDLE;
                    end else begin
                        data_d  = mst_rdata;
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                if (abt) begin
                    state_d = IDLE;
                end else if (s_hs) begin
                    if (!last_sel) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = WR_SEL;
                    end else if (!last_idx) begin
                        sel_d   = '0;
                        idx_d   = idx_q + BUFFER_W'(1);
                        state_d = WR_IDX;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        abort_d = (state_d == IDLE) ? 1'b0 : abt;
    end

    // Outputs decoded from the current state
    always_comb begin
        mst_req   = 1'b0;
        mst_we    = 1'b0;
        mst_addr  = '0;
        mst_wdata = '0;
        s_valid_o = 1'b0;
        s_last_o  = 1'b0;
        done_o    = 1'b0;
        busy_o    = busy;
        s_data_o  = data_q;
        case (state_q)
            RD_NS: begin
                mst_req  = 1'b1;
                mst_addr = NSAMP_ADDR;
            end
            WR_IDX: begin
                mst_req   = 1'b1;
                mst_we    = 1'b1;
                mst_addr  = INDEX_ADDR;
                mst_wdata = DATA_W'(idx_q);
            end
            WR_SEL: begin
                mst_req   = 1'b1;
                mst_we    = 1'b1;
                mst_addr  = SEL_ADDR;
                mst_wdata = DATA_W'(sel_q);
            end
            RD_DAT: begin
                mst_req  = 1'b1;
                mst_addr = SAMPLE_ADDR;
            end
            PUSH: begin
                s_valid_o = cke_i;
                s_last_o  = last_sel && last_idx;
            end
            FIN:     done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iob_ila_dump_ctrl.sv
// Directed bench for iob_ila_dump_ctrl: ILA register-bus model plus stream sink with hand-derived expectations.
// Latency: checks start-to-done cycle counts on a zero-wait bus.
// Backpressure: exercises bus accept stalls, delayed rvalid and stream sink stalls.
module tb_iob_ila_dump_ctrl;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  words_i = '0;
    logic        busy_o, done_o, m_avalid_o, s_valid_o, s_last_o;
    logic [7:0]  m_addr_o;
    logic [31:0] m_wdata_o, s_data_o;
    logic [3:0]  m_wstrb_o;
    logic        m_ready_i = 1'b0;
    logic        m_rvalid_i = 1'b0;
    logic [31:0] m_rdata_i = '0;
    logic        s_ready_i = 1'b1;

    iob_ila_dump_ctrl dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .words_i    (words_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .m_avalid_o (m_avalid_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .s_valid_o  (s_valid_o),
        .s_data_o   (s_data_o),
        .s_last_o   (s_last_o),
        .s_ready_i  (s_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // bus / sink model configuration and observations
    int          cfg_nsamp = 0, max_stall = 0, rv_delay = 1, sstall_left = 0;
    int          rv_cnt = 0, stall_left = 0;
    logic [31:0] rv_data = '0;
    logic        held_vld = 1'b0;
    logic [7:0]  held_addr;
    logic [31:0] held_wdata;
    logic [3:0]  held_wstrb;
    logic        s_held = 1'b0;
    logic [31:0] sh_data;
    logic        sh_last;
    logic [9:0]  reg_idx = '0;
    logic [7:0]  reg_sel = '0;
    logic [31:0] got_data[$];
    logic        got_last[$];
    int          idx_log[$];
    int          sel_log[$];
    int          nsamp_reads = 0, done_cnt = 0, done_cyc = -1, rv_cyc = -1, busy_fall_cyc = -1, st_cyc = 0;
    logic        busy_prev = 1'b0;
    logic        abort_arm = 1'b0, abort_next = 1'b0;

    function automatic logic [31:0] exp_word(input int i, input int s);
        exp_word = 32'hA500_0000 | (i << 8) | s;
    endfunction

    // ILA register bus, stream sink and event monitor, evaluated 1 time unit after each edge
    initial begin : bus_model
        forever begin
            @(posedge clk_i);
            #1;
            abort_i = 1'b0;
            if (abort_next) begin
                abort_i    = 1'b1;
                abort_next = 1'b0;
            end
            m_rvalid_i = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i  = rv_data;
                    rv_cyc     = cyc;
                end
            end
            m_ready_i = 1'b0;
            if (held_vld) check_eq("avalid_hold", m_avalid_o, 1);
            if (m_avalid_o) begin
                check_eq("one_outstanding", (rv_cnt > 0) || m_rvalid_i, 0);
                if (!held_vld) begin
                    held_vld   = 1'b1;
                    held_addr  = m_addr_o;
                    held_wdata = m_wdata_o;
                    held_wstrb = m_wstrb_o;
                    stall_left = $urandom_range(0, max_stall);
                end else begin
                    check_eq("addr_stable", m_addr_o, held_addr);
                    check_eq("wdata_stable", m_wdata_o, held_wdata);
                    check_eq("wstrb_stable", m_wstrb_o, held_wstrb);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    m_ready_i = 1'b1;
                    held_vld  = 1'b0;
                    case (m_addr_o)
                        8'h1C: begin
                            check_eq("wstrb_rd_ns", m_wstrb_o, 4'h0);
                            nsamp_reads++;
                            rv_data = 32'hDEAD_0000 | cfg_nsamp;
                            rv_cnt  = rv_delay;
                        end
                        8'h18: begin
                            check_eq("wstrb_rd_dat", m_wstrb_o, 4'h0);
                            rv_data = {8'hA5, 6'd0, reg_idx, reg_sel};
                            rv_cnt  = rv_delay;
                            if (abort_arm) begin
                                abort_arm  = 1'b0;
                                abort_next = 1'b1;
                            end
                        end
                        8'h10: begin
                            check_eq("wstrb_wr_idx", m_wstrb_o, 4'hF);
                            reg_idx = m_wdata_o[9:0];
                            idx_log.push_back(int'(m_wdata_o));
                        end
                        8'h14: begin
                            check_eq("wstrb_wr_sel", m_wstrb_o, 4'hF);
                            reg_sel = m_wdata_o[7:0];
                            sel_log.push_back(int'(m_wdata_o));
                        end
                        default: check_eq("bus_addr_known", m_addr_o, 8'h1C);
                    endcase
                end
            end
            s_ready_i = 1'b1;
            if (s_held && !s_valid_o) check_eq("s_valid_hold", s_valid_o, 1);
            if (s_valid_o && sstall_left > 0) begin
                if (!s_held) begin
                    s_held  = 1'b1;
                    sh_data = s_data_o;
                    sh_last = s_last_o;
                end else begin
                    check_eq("s_data_hold", s_data_o, sh_data);
                    check_eq("s_last_hold", s_last_o, sh_last);
                end
                check_eq("no_req_in_push", m_avalid_o, 0);
                sstall_left--;
                s_ready_i = 1'b0;
            end else if (s_valid_o) begin
                if (s_held) check_eq("s_data_after_stall", s_data_o, sh_data);
                s_held = 1'b0;
                got_data.push_back(s_data_o);
                got_last.push_back(s_last_o);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_prev && !busy_o) busy_fall_cyc = cyc;
            busy_prev = busy_o;
        end
    end

    task automatic run_dump(input int ns, input int w, input int mstall, input int rvd,
                            input int sst, input logic do_abort);
        cfg_nsamp = ns;
        max_stall = mstall;
        rv_delay  = rvd;
        sstall_left = sst;
        abort_arm = do_abort;
        words_i   = 8'(w);
        got_data.delete();
        got_last.delete();
        idx_log.delete();
        sel_log.delete();
        nsamp_reads = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        rv_cyc      = -1;
        busy_fall_cyc = -1;
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        st_cyc  = cyc;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check_eq("busy_after_start", busy_o, 1);
        for (int k = 0; k < 3000 && busy_o; k++) begin
            @(posedge clk_i);
            #1;
        end
        check_eq("dump_terminates", busy_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_stream(input int ns, input int w);
        int wc;
        int k;
        wc = (w == 0) ? 1 : w;
        k  = 0;
        check_eq("stream_count", got_data.size(), ns * wc);
        for (int i = 0; i < ns; i++) begin
            for (int s = 0; s < wc; s++) begin
                if (k < got_data.size()) begin
                    check_eq("s_data", got_data[k], exp_word(i, s));
                    check_eq("s_last", got_last[k], (i == ns - 1) && (s == wc - 1));
                end
                k++;
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_avalid", m_avalid_o, 0);
        check_eq("rst_addr", m_addr_o, 0);
        check_eq("rst_wdata", m_wdata_o, 0);
        check_eq("rst_wstrb", m_wstrb_o, 0);
        check_eq("rst_s_valid", s_valid_o, 0);
        check_eq("rst_s_data", s_data_o, 0);
        check_eq("rst_s_last", s_last_o, 0);
        arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 3 samples, 1 word each, zero-wait bus
        run_dump(3, 1, 0, 1, 0, 1'b0);
        check_stream(3, 1);
        check_eq("t1_nsamp_reads", nsamp_reads, 1);
        check_eq("t1_idx_writes", idx_log.size(), 3);
        for (int i = 0; i < 3 && i < idx_log.size(); i++) check_eq("t1_idx_val", idx_log[i], i);
        check_eq("t1_sel_writes", sel_log.size(), 3);
        for (int i = 0; i < 3 && i < sel_log.size(); i++) check_eq("t1_sel_val", sel_log[i], 0);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_done_latency", done_cyc - st_cyc, 18);

        // 2 samples, 3 words each
        run_dump(2, 3, 0, 1, 0, 1'b0);
        check_stream(2, 3);
        check_eq("t2_idx_writes", idx_log.size(), 2);
        for (int i = 0; i < 2 && i < idx_log.size(); i++) check_eq("t2_idx_val", idx_log[i], i);
        check_eq("t2_sel_writes", sel_log.size(), 6);
        for (int i = 0; i < 6 && i < sel_log.size(); i++) check_eq("t2_sel_val", sel_log[i], i % 3);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_done_latency", done_cyc - st_cyc, 29);

        // empty buffer
        run_dump(0, 2, 0, 1, 0, 1'b0);
        check_eq("t3_nsamp_reads", nsamp_reads, 1);
        check_eq("t3_stream_count", got_data.size(), 0);
        check_eq("t3_writes", idx_log.size() + sel_log.size(), 0);
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_done_latency", done_cyc - st_cyc, 3);

        // accept stalls 0-4 cycles, rvalid 3 cycles after accept
        run_dump(3, 2, 4, 3, 0, 1'b0);
        check_stream(3, 2);
        check_eq("t4_done_cnt", done_cnt, 1);

        // sink holds s_ready low for 10 cycles on the first word
        run_dump(1, 2, 0, 1, 10, 1'b0);
        check_stream(1, 2);
        check_eq("t5_stall_consumed", sstall_left, 0);
        check_eq("t5_done_cnt", done_cnt, 1);

        // abort while the first SAMPLE_DATA read is outstanding
        run_dump(2, 1, 0, 3, 0, 1'b1);
        check_eq("t6_stream_count", got_data.size(), 0);
        check_eq("t6_done_cnt", done_cnt, 0);
        check_eq("t6_busy_fall_after_rvalid",
                 (busy_fall_cyc - rv_cyc >= 1) && (busy_fall_cyc - rv_cyc <= 2), 1);
        check_eq("t6_no_pending_read", rv_cnt, 0);

        // full dump after the abort
        run_dump(2, 1, 0, 1, 0, 1'b0);
        check_stream(2, 1);
        check_eq("t7_done_cnt", done_cnt, 1);
        check_eq("t7_done_latency", done_cyc - st_cyc, 13);

        // words_i = 0 behaves as one word per sample
        run_dump(1, 0, 0, 1, 0, 1'b0);
        check_stream(1, 0);
        check_eq("t8_done_cnt", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
